uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx.sv | 155 +++++++++++++++
 tb/tb_uart_byte_rx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver (LSB first, idle-high line) with
// start-bit glitch rejection, framing-error detection and break handling.
//
// Parameters
//   CLK_HZ    system clock frequency in Hz
//   BAUD      serial bit rate; one bit lasts CLK_HZ/BAUD clocks
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   rx        asynchronous serial input
//   rx_data   last correctly framed byte, held until the next good byte
//   rx_int    busy flag from start-bit validation to the stop-bit sample
//   rx_valid  one-cycle pulse when rx_data is updated
//   frame_err one-cycle pulse when the stop bit samples low
module uart_byte_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int BIT_CNT = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CNT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    data_q, data_d;
  logic          int_q, int_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    int_d   = int_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // rx_prev_q tracks rx_s_q in every state, so a start edge right
        // after the stop-bit sample is still seen here.
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
            int_d   = 1'b1;
          end else begin
            // Line went back high before mid-bit: treat as noise.
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          // LSB arrives first, so shift right and fill from the top.
          sr_d  = {rx_s_q, sr_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          int_d = 1'b0;
          if (rx_s_q) begin
            data_d  = sr_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it cannot be taken as a new start.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      sr_q      <= 8'h00;
      data_q    <= 8'h00;
      int_q     <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      int_q     <= int_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_int    = int_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx at 16 clocks per bit. A line driver serialises
// bytes; the reference model is simply the list of bytes sent with a good
// stop bit, plus timing facts of an 8N1 frame (144-cycle busy window,
// 160-cycle byte spacing when sent back-to-back).
module tb_uart_byte_rx;

  localparam int BITC = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       rx_valid;
  logic       frame_err;

  uart_byte_rx #(
    .CLK_HZ(1_600_000),
    .BAUD  (100_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_int   (rx_int),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         valid_cyc[$];
  int cyc = 0;
  int valid_cnt = 0, ferr_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int rise_cyc = 0, last_high_len = 0;
  logic [7:0] prev_data = 8'h00;
  logic prev_int = 1'b0, prev_valid = 1'b0, prev_ferr = 1'b0;

  // Monitor: protocol invariants every cycle plus event bookkeeping.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      vectors = vectors + 1;
      if (rx_valid && frame_err) begin
        miscompares++;
        $display("FAIL excl: rx_valid=%b frame_err=%b both high, required not both (cycle %0d)", rx_valid, frame_err, cyc);
      end
      if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) begin
        miscompares++;
        $display("FAIL pulse_width: rx_valid/frame_err high two cycles, required one-cycle pulse (cycle %0d)", cyc);
      end
      if (rx_data !== prev_data && !rx_valid) begin
        miscompares++;
        $display("FAIL data_hold: rx_data 0x%02h -> 0x%02h without rx_valid (cycle %0d)", prev_data, rx_data, cyc);
      end
      if (prev_int && !rx_int && !(rx_valid || frame_err)) begin
        miscompares++;
        $display("FAIL int_fall: rx_int fell without rx_valid/frame_err (cycle %0d)", cyc);
      end
      if ((rx_valid || frame_err) && (rx_int || !prev_int)) begin
        miscompares++;
        $display("FAIL int_align: pulse with rx_int=%b prev=%b, required falling edge same cycle (cycle %0d)", rx_int, prev_int, cyc);
      end
    end
    if (rx_valid === 1'b1) begin
      got_q.push_back(rx_data);
      valid_cyc.push_back(cyc);
      valid_cnt++;
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (!prev_int && rx_int === 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (prev_int && rx_int === 1'b0) begin
      fall_cnt++;
      last_high_len = cyc - rise_cyc;
    end
    prev_data  = rx_data;
    prev_int   = (rx_int === 1'b1);
    prev_valid = (rx_valid === 1'b1);
    prev_ferr  = (frame_err === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BITC);
    end
    rx = stop_bit;
    tick(BITC);
    if (stop_bit) exp_q.push_back(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    tick(4);
    vectors++;
    if ({rx_data, rx_int, rx_valid, frame_err} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: data=0x%02h int=%b valid=%b ferr=%b, required all 0", rx_data, rx_int, rx_valid, frame_err);
    end
    rst = 1'b0;
    tick(20);
    vectors++;
    if ({rx_data, rx_int, rx_valid, frame_err} !== 11'd0 || rise_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_idle: data=0x%02h int=%b rises=%0d, required 0/0/0", rx_data, rx_int, rise_cnt);
    end
  endtask

  task automatic test_single();
    int f0 = fall_cnt;
    logic [7:0] e, g;
    send_byte(8'h55, 1'b1);
    tick(5);
    vectors++;
    if (last_high_len != 9 * BITC || fall_cnt != f0 + 1 || rx_int !== 1'b0) begin
      miscompares++;
      $display("FAIL single_int: high_len=%0d falls=%0d, required %0d/%0d", last_high_len, fall_cnt - f0, 9 * BITC, 1);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL single_data: got 0x%02h, required 0x%02h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
    valid_cyc.delete();
    $display("single: sent 0x55, rx_data=0x%02h", rx_data);
  endtask

  task automatic test_back_to_back();
    int f0 = fall_cnt;
    logic [7:0] e, g;
    logic [7:0] r = 8'($urandom);
    valid_cyc.delete();
    send_byte(8'h55, 1'b1);
    send_byte(8'h53, 1'b1);
    send_byte(r, 1'b1);
    tick(5);
    vectors++;
    if (valid_cyc.size() != 3 || fall_cnt != f0 + 3) begin
      miscompares++;
      $display("FAIL b2b_count: pulses=%0d falls=%0d, required 3/3", valid_cyc.size(), fall_cnt - f0);
    end else begin
      vectors++;
      if (valid_cyc[1] - valid_cyc[0] != 10 * BITC || valid_cyc[2] - valid_cyc[1] != 10 * BITC) begin
        miscompares++;
        $display("FAIL b2b_spacing: gaps %0d,%0d cycles, required %0d", valid_cyc[1] - valid_cyc[0], valid_cyc[2] - valid_cyc[1], 10 * BITC);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL b2b_data: got 0x%02h, required 0x%02h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
    $display("back_to_back: sent 55 53 %02h", r);
  endtask

  task automatic test_glitch();
    int r0 = rise_cnt, v0 = valid_cnt, e0 = ferr_cnt;
    logic [7:0] e, g;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    vectors++;
    if (rise_cnt != r0 || valid_cnt != v0 || ferr_cnt != e0) begin
      miscompares++;
      $display("FAIL glitch_reject: rises=%0d valids=%0d ferrs=%0d, required 0/0/0", rise_cnt - r0, valid_cnt - v0, ferr_cnt - e0);
    end
    send_byte(8'hA7, 1'b1);
    tick(2);
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL glitch_count: got %0d bytes, required 1", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL glitch_data: got 0x%02h, required 0x%02h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
    $display("glitch: 4-cycle low rejected, then 0xA7");
  endtask

  task automatic test_frame_err();
    int r0, v0, e0;
    logic [7:0] d0, e, g;
    d0 = rx_data;
    r0 = rise_cnt;
    v0 = valid_cnt;
    e0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    rx = 1'b0;
    tick(40);
    vectors++;
    if (ferr_cnt != e0 + 1 || valid_cnt != v0 || rx_data !== d0) begin
      miscompares++;
      $display("FAIL ferr_pulse: ferrs=%0d valids=%0d data=0x%02h, required 1/0/0x%02h", ferr_cnt - e0, valid_cnt - v0, rx_data, d0);
    end
    vectors++;
    if (rise_cnt != r0 + 1) begin
      miscompares++;
      $display("FAIL ferr_break: rises=%0d during low line, required 1", rise_cnt - r0);
    end
    rx = 1'b1;
    tick(20);
    vectors++;
    if (rise_cnt != r0 + 1 || ferr_cnt != e0 + 1) begin
      miscompares++;
      $display("FAIL ferr_release: rises=%0d ferrs=%0d, required 1/1", rise_cnt - r0, ferr_cnt - e0);
    end
    send_byte(8'($urandom), 1'b1);
    tick(2);
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL ferr_recover_count: got %0d bytes, required 1", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL ferr_recover: got 0x%02h, required 0x%02h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
    $display("frame_err: 0x3C with low stop, rx_data held 0x%02h", d0);
  endtask

  task automatic test_reset_mid();
    int v0 = valid_cnt, e0 = ferr_cnt;
    logic [7:0] e, g;
    rx = 1'b0;
    tick(BITC);
    rx = 1'b1;
    tick(4 * BITC + BITC / 2);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    vectors++;
    if ({rx_data, rx_int, rx_valid, frame_err} !== 11'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: data=0x%02h int=%b valid=%b ferr=%b, required all 0", rx_data, rx_int, rx_valid, frame_err);
    end
    tick(4 * BITC);
    vectors++;
    if (valid_cnt != v0 || ferr_cnt != e0 || rx_int !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_abort: valids=%0d ferrs=%0d int=%b, required 0/0/0", valid_cnt - v0, ferr_cnt - e0, rx_int);
    end
    send_byte(8'h12, 1'b1);
    tick(2);
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d bytes, required 1", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL midreset_data: got 0x%02h, required 0x%02h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
    $display("reset_mid: 0xFF aborted at bit 4, then 0x12");
  endtask

  task automatic test_sensor_frame();
    logic [7:0] frame[11];
    logic [7:0] sum = 8'h00;
    logic [7:0] e, g;
    int v0 = valid_cnt, f0 = fall_cnt;
    frame[0] = 8'h55;
    frame[1] = 8'h53;
    for (int i = 2; i < 10; i++) frame[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) sum = sum + frame[i];
    frame[10] = sum;
    for (int i = 0; i < 11; i++) send_byte(frame[i], 1'b1);
    tick(2);
    vectors++;
    if (valid_cnt != v0 + 11 || fall_cnt != f0 + 11) begin
      miscompares++;
      $display("FAIL frame_count: valids=%0d falls=%0d, required 11/11", valid_cnt - v0, fall_cnt - f0);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL frame_data: got 0x%02h, required 0x%02h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
    $display("sensor_frame: 11 bytes, checksum 0x%02h", sum);
  endtask

  task automatic test_random();
    logic [7:0] e, g;
    int n;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'($urandom), 1'b1);
      rx = 1'b1;
      tick($urandom_range(0, 24));
    end
    tick(2);
    n = exp_q.size();
    vectors++;
    if (got_q.size() != n) begin
      miscompares++;
      $display("FAIL random_count: got %0d bytes, required %0d", got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL random_data: got 0x%02h, required 0x%02h", g, e);
      end
    end
    exp_q.delete();
    got_q.delete();
    $display("random: %0d bytes with random idle gaps", n);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_sensor_frame();
    test_random();
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
